input_fetch_seq: RTL and testbench
==================================

Name: input_fetch_seq

Overview:
- Sequencer directly upstream of the input-side sorting register.
- Reads 32-bit words from the input SRAM buffer through a small prefetch FIFO.
- Presents each word on `buffer` for 1, 2 or 4 consecutive phases, driving the 2-bit `state` phase index that the sorting register uses to pick sub-fields.
- The phase count follows the latched weight bitwidth. Valid/ready backpressure lets the PE array stall the stream.

Parameters:
- ADDR_W, 10, input SRAM word-address width.
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- CNT_W, 16, width of the word-count input.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse; begins a transfer when idle.
- base_addr  input  ADDR_W  first SRAM word address, latched on start.
- num_words  input  CNT_W  number of words to stream, latched on start.
- weight_bitwidth  input  2  00=8b (1 phase), 01=4b (2 phases), 10/11=2b (4 phases); latched on start.
- mem_rd_en  output  1  SRAM read strobe.
- mem_addr  output  ADDR_W  SRAM read address.
- mem_rd_data  input  32  SRAM data, valid exactly 1 cycle after mem_rd_en.
- buffer  output  32  FIFO head word presented downstream.
- state  output  2  current phase index for the presented word.
- out_valid  output  1  buffer/state valid.
- out_ready  input  1  downstream accepts this phase.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when the final phase of the final word is accepted.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - FSM goes to IDLE; FIFO is emptied; in-flight read is discarded.
  - All outputs are 0: mem_rd_en, mem_addr, buffer, state, out_valid, busy, done.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on start with num_words != 0. base_addr, num_words and weight_bitwidth are latched.
  - IDLE on start with num_words == 0: no reads are issued; done pulses the next cycle; FSM stays IDLE.
  - RUN -> FLUSH when the last read has been issued.
  - FLUSH -> IDLE when the last phase of the last word is accepted. done pulses in that same transition cycle.
  - start is ignored while busy. busy = (state != IDLE).
- Read issue:
  - mem_rd_en is asserted in RUN when words_remaining != 0 and (fifo_count + inflight) < FIFO_DEPTH.
  - mem_addr increments by 1 per issued read, starting at base_addr. It wraps modulo 2^ADDR_W with no error.
  - First read is issued in the cycle after start.
  - Read data is pushed into the FIFO on the following cycle. The FIFO can never overflow.
- Output side:
  - out_valid = FIFO not empty. buffer = FIFO head (combinational from storage). state = phase counter.
  - On out_valid && out_ready:
    - If phase == last_phase: the FIFO is popped and phase returns to 0.
    - Otherwise phase increments.
    - last_phase = 0 for bw 00, 1 for bw 01, 3 for bw 10/11.
  - state stays 00 throughout in 8b mode.
  - With out_ready held low, buffer, state and out_valid remain stable.
- Simultaneous push and pop in the same cycle is allowed; count is unchanged.
- Minimum latency: start at cycle 0 -> read at cycle 1 -> FIFO push at cycle 2 -> out_valid high at cycle 3.
- Sustained throughput with out_ready held high: one word per (last_phase+1) cycles. In 8b mode this is one word per cycle with no bubbles.

Optional Feature:
- Macro INPUT_FETCH_PERF_EN.
- When defined: adds output port `stall_cycles` [31:0]. It counts cycles with out_valid && !out_ready and separately-summed cycles with busy && !out_valid (starvation). Cleared on reset and on an accepted start. Saturates at 32'hFFFFFFFF.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- bw=00, base=0x010, num=3, out_ready=1, SRAM[0x10..0x12]=A0A1A2A3/B0B1B2B3/C0C1C2C3 -> reads at 0x010..0x012; buffer shows the three words on consecutive cycles with state=00; done pulses once; busy falls the same cycle as done.
- bw=01, num=2 -> each word is held 2 accepted cycles with state 00 then 01; 4 handshakes total, then done.
- bw=10, num=1, out_ready toggling 1,0,1,0,... -> state steps 00,01,10,11 only on ready cycles; buffer is stable across stalls; done after the 4th accept.
- out_ready=0 for 20 cycles, bw=00, num=10 -> exactly FIFO_DEPTH (4) reads issued, then mem_rd_en stays low; on release all 10 words arrive in order.
- base=0x3FE, num=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- num=0 start -> done pulses the next cycle with no mem_rd_en. Separately, reset asserted mid-transfer with bw=01 -> all outputs 0 immediately; a subsequent start streams correctly from its new base_addr.

Source files
------------

// File: rtl/input_fetch_seq.sv
// input_fetch_seq: reads words from the input SRAM into a small prefetch FIFO
// and presents each word for 1, 2 or 4 phases to the input sorting register.
// Ports: clk/reset (async, active high); start, base_addr, num_words,
// weight_bitwidth (latched on start); mem_rd_en/mem_addr/mem_rd_data (SRAM,
// 1-cycle read latency); buffer/state/out_valid/out_ready (phase stream);
// busy, done. Define INPUT_FETCH_PERF_EN to add the stall_cycles counter.
module input_fetch_seq #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [1:0]        weight_bitwidth,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [31:0]       buffer,
  output logic [1:0]        state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef INPUT_FETCH_PERF_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fsm_t;

  fsm_t fsm, fsm_nxt;

  logic [CNT_W-1:0] rd_left;
  logic [CNT_W-1:0] out_left;
  logic [1:0]       last_phase;
  logic [1:0]       phase;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             inflight;
  logic             zero_done;
  logic             go;
  logic             push;
  logic             pop;
  logic             accept;
  logic             last_word;

  assign go = start && (fsm == IDLE) && (num_words != '0);

  // Reserve a FIFO slot for the read already in flight so a push
  // can never find the FIFO full.
  assign mem_rd_en = (fsm == RUN) && (rd_left != '0) &&
                     ((count + {{PW{1'b0}}, inflight}) < DEPTH_C);

  assign out_valid = (count != '0);
  assign buffer    = out_valid ? fifo_mem[rd_ptr] : '0;
  assign state     = phase;
  assign busy      = (fsm != IDLE);

  assign accept    = out_valid && out_ready;
  assign pop       = accept && (phase == last_phase);
  assign push      = inflight;
  assign last_word = (out_left == CNT_W'(1));

  assign done = zero_done || ((fsm == FLUSH) && pop && last_word);

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (go) fsm_nxt = RUN;
      RUN:     if (mem_rd_en && rd_left == CNT_W'(1)) fsm_nxt = FLUSH;
      FLUSH:   if (pop && last_word) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm        <= IDLE;
      rd_left    <= '0;
      out_left   <= '0;
      last_phase <= '0;
      phase      <= '0;
      mem_addr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      zero_done  <= 1'b0;
    end else begin
      fsm       <= fsm_nxt;
      inflight  <= mem_rd_en;
      zero_done <= start && (fsm == IDLE) && (num_words == '0);
      if (go) begin
        mem_addr <= base_addr;
        rd_left  <= num_words;
        out_left <= num_words;
        phase    <= '0;
        case (weight_bitwidth)
          2'b00:   last_phase <= 2'd0;
          2'b01:   last_phase <= 2'd1;
          default: last_phase <= 2'd3;
        endcase
      end else begin
        if (mem_rd_en) begin
          mem_addr <= mem_addr + ADDR_W'(1);
          rd_left  <= rd_left - CNT_W'(1);
        end
        if (pop) begin
          out_left <= out_left - CNT_W'(1);
        end
      end
      if (accept) begin
        phase <= pop ? 2'd0 : phase + 2'd1;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rd_data;
  end

`ifdef INPUT_FETCH_PERF_EN
  // Back-pressure and starvation are mutually exclusive, so at most
  // one increment per cycle.
  logic stall_ev;
  assign stall_ev = (out_valid && !out_ready) || (busy && !out_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (start && fsm == IDLE) begin
      stall_cycles <= '0;
    end else if (stall_ev && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_input_fetch_seq.sv
// tb_input_fetch_seq: scoreboard bench for input_fetch_seq.
// SRAM model, expected phase/word and address queues, per-scenario checks.
module tb_input_fetch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [15:0] num_words = '0;
  logic [1:0]  weight_bitwidth = '0;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] buffer;
  logic [1:0]  state;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
`ifdef INPUT_FETCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  input_fetch_seq dut (
`ifdef INPUT_FETCH_PERF_EN
    .stall_cycles   (stall_cycles),
`endif
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .weight_bitwidth(weight_bitwidth),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .buffer         (buffer),
    .state          (state),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [1024];

  always @(posedge clk) mem_rd_data <= sram[mem_addr];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [33:0] exp_q[$];
  logic [9:0]  addr_q[$];
  logic [33:0] e;
  int cyc = 0;
  int rd_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int first_acc = 0;
  int last_acc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_buf = '0;
  logic [1:0]  prev_st = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) check("rd_extra", 1, 0);
        else check("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (prev_stall) begin
        check("hold_buf", buffer, prev_buf);
        check("hold_st", 32'(state), 32'(prev_st));
        check("hold_vld", 32'(out_valid), 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_buf   = buffer;
      prev_st    = state;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (acc_cnt == 1) first_acc = cyc;
        last_acc = cyc;
        if (exp_q.size() == 0) begin
          check("acc_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("buf", buffer, e[31:0]);
          check("state", 32'(state), 32'(e[33:32]));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_q_empty", exp_q.size(), 0);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_start(input logic [9:0] b, input int n,
                          input logic [1:0] bw);
    logic [9:0] a;
    int lp;
    @(posedge clk);
    #1;
    base_addr       = b;
    num_words       = 16'(n);
    weight_bitwidth = bw;
    start           = 1'b1;
    acc_cnt  = 0;
    rd_cnt   = 0;
    done_cnt = 0;
    lp = (bw == 2'b00) ? 0 : (bw == 2'b01) ? 1 : 3;
    for (int i = 0; i < n; i++) begin
      a = b + 10'(i);
      addr_q.push_back(a);
      for (int p = 0; p <= lp; p++) exp_q.push_back({2'(p), sram[a]});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (done_cnt == 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_buffer"}, buffer, 0);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] ai;
    for (int i = 0; i < 1024; i++) begin
      ai = 10'(i);
      sram[i] = {12'hC5A, ai, ~ai};
    end
    sram[10'h010] = 32'hA0A1A2A3;
    sram[10'h011] = 32'hB0B1B2B3;
    sram[10'h012] = 32'hC0C1C2C3;

    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 8b mode, minimum latency and back-to-back words
    do_start(10'h010, 3, 2'b00);
    @(negedge clk);
    check("lat_rd_c1", 32'(mem_rd_en), 1);
    @(negedge clk);
    check("lat_vld_c2", 32'(out_valid), 0);
    @(negedge clk);
    check("lat_vld_c3", 32'(out_valid), 1);
    wait_done(50);
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_acc", acc_cnt, 3);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_span", last_acc - first_acc, 2);
    check("t1_reads", rd_cnt, 3);

    // 4b mode: two phases per word
    do_start(10'h020, 2, 2'b01);
    wait_done(50);
    check("t2_acc", acc_cnt, 4);
    check("t2_done_cnt", done_cnt, 1);

    // 2b mode with toggling ready
    do_start(10'h030, 1, 2'b10);
    begin
      int n = 0;
      while (done_cnt == 0 && n < 60) begin
        @(posedge clk);
        #1;
        out_ready = ~out_ready;
        n++;
      end
      if (done_cnt == 0) check("t3_timeout", 0, 1);
    end
    out_ready = 1'b1;
    check("t3_acc", acc_cnt, 4);

    // long stall: prefetch stops at FIFO depth
    out_ready = 1'b0;
    do_start(10'h100, 10, 2'b00);
    repeat (20) @(posedge clk);
    #1;
    check("t4_stall_reads", rd_cnt, 4);
    out_ready = 1'b1;
    wait_done(100);
    check("t4_acc", acc_cnt, 10);
    check("t4_reads", rd_cnt, 10);

    // address wrap
    do_start(10'h3FE, 4, 2'b00);
    wait_done(50);
    check("t5_reads", rd_cnt, 4);
    check("t5_acc", acc_cnt, 4);

    // zero-length transfer
    do_start(10'h050, 0, 2'b00);
    @(negedge clk);
    check("t6_done_c1", 32'(done), 1);
    check("t6_busy", 32'(busy), 0);
    @(negedge clk);
    check("t6_done_c2", 32'(done), 0);
    check("t6_reads", rd_cnt, 0);

    // reset mid-transfer, then restart at a new base
    do_start(10'h200, 8, 2'b01);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_start(10'h300, 3, 2'b01);
    wait_done(60);
    check("t7_acc", acc_cnt, 6);
    check("t7_reads", rd_cnt, 3);
    check("t7_q_left", exp_q.size() + addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
